// File: rtl/keyboard_action_decoder_pkg.sv
// Shared constants and types for the PS/2 Set-2 keyboard action decoder.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_NUL   = 8'h00;
  localparam logic [7:0] SC_OVR   = 8'hFF;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_RSND  = 8'hFE;
  localparam logic [7:0] SC_ECHO  = 8'hEE;

  // Player 1: plain codes
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  // Player 2: E0-prefixed arrows, plain Enter
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int NUM_ACT = 5;
  localparam logic [2:0] ACT_UP    = 3'd0;
  localparam logic [2:0] ACT_DOWN  = 3'd1;
  localparam logic [2:0] ACT_LEFT  = 3'd2;
  localparam logic [2:0] ACT_RIGHT = 3'd3;
  localparam logic [2:0] ACT_BOMB  = 3'd4;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} kbd_state_e;

endpackage

// File: rtl/keyboard_action_decoder_if.sv
// Scan-byte input and action outputs of the keyboard decoder.
interface keyboard_action_decoder_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [4:0] p1_actions;
    logic [4:0] p2_actions;
    logic [9:0] press_evt;
    logic       pause;
    logic       parse_err;

    modport master (output scan_code, scan_valid,
                    input  p1_actions, p2_actions, press_evt, pause, parse_err);
    modport slave  (input  scan_code, scan_valid,
                    output p1_actions, p2_actions, press_evt, pause, parse_err);
endinterface

// File: rtl/keyboard_action_decoder_keymap.sv
// Combinational lookup of {ext, code} to a game key slot or the Esc key.
module kbd_keymap
    import keyboard_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output logic       hit_o,
    output logic       player_o,
    output logic [2:0] act_o,
    output logic       esc_o
);
    always_comb begin
        hit_o    = 1'b1;
        player_o = 1'b0;
        act_o    = ACT_UP;
        esc_o    = 1'b0;
        // The ext flag is part of the match: plain 75 and E0 5A fall through.
        case ({ext_i, code_i})
            {1'b0, SC_W}:     act_o = ACT_UP;
            {1'b0, SC_S}:     act_o = ACT_DOWN;
            {1'b0, SC_A}:     act_o = ACT_LEFT;
            {1'b0, SC_D}:     act_o = ACT_RIGHT;
            {1'b0, SC_SPACE}: act_o = ACT_BOMB;
            {1'b1, SC_UP}:    begin player_o = 1'b1; act_o = ACT_UP;    end
            {1'b1, SC_DOWN}:  begin player_o = 1'b1; act_o = ACT_DOWN;  end
            {1'b1, SC_LEFT}:  begin player_o = 1'b1; act_o = ACT_LEFT;  end
            {1'b1, SC_RIGHT}: begin player_o = 1'b1; act_o = ACT_RIGHT; end
            {1'b0, SC_ENTER}: begin player_o = 1'b1; act_o = ACT_BOMB;  end
            {1'b0, SC_ESC}:   begin hit_o = 1'b0; esc_o = 1'b1; end
            default:          hit_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/keyboard_action_decoder.sv
// PS/2 Set-2 scan byte parser holding two players' game keys and a pause toggle.
// Optional prefix timeout enabled by defining KBD_TIMEOUT_EN.
module keyboard_action_decoder
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int SKIP_BYTES     = 7
) (
    input  logic                        clk,
    input  logic                        reset_n,
    keyboard_action_decoder_if.slave    bus
);
    localparam int SKW = $clog2(SKIP_BYTES + 1);

    kbd_state_e     state_q, state_d;
    logic [SKW-1:0] skip_q, skip_d;
    logic [9:0]     keys_q, keys_d, evt_q, evt_d;
    logic           pause_q, pause_d, esc_q, esc_d, err_q, err_d;

    logic       ext, hit, player, is_esc, do_make, do_brk, overrun, ignored;
    logic [2:0] act;
    logic [3:0] key_idx;

    assign ext     = (state_q == EXT) || (state_q == EXT_BRK);
    assign overrun = (bus.scan_code == SC_NUL) || (bus.scan_code == SC_OVR);
    assign ignored = (bus.scan_code == SC_BAT) || (bus.scan_code == SC_ACK) ||
                     (bus.scan_code == SC_RSND) || (bus.scan_code == SC_ECHO);
    assign key_idx = (player ? 4'(NUM_ACT) : 4'd0) + 4'(act);

    kbd_keymap u_keymap (
        .ext_i    (ext),
        .code_i   (bus.scan_code),
        .hit_o    (hit),
        .player_o (player),
        .act_o    (act),
        .esc_o    (is_esc)
    );

`ifdef KBD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;

    // Reloads on every byte; only counts while a multi-byte sequence is open.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                tmo_q <= '0;
        else if (bus.scan_valid || state_q == IDLE)  tmo_q <= '0;
        else                                         tmo_q <= tmo_q + TW'(1);
    end
    assign tmo_hit = !bus.scan_valid && (state_q != IDLE) &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        keys_d  = keys_q;
        evt_d   = '0;
        err_d   = 1'b0;
        pause_d = pause_q;
        esc_d   = esc_q;
        do_make = 1'b0;
        do_brk  = 1'b0;
        if (bus.scan_valid) begin
            if (overrun && state_q != SKIP) begin
                state_d = IDLE;
                keys_d  = '0;
                esc_d   = 1'b0;
                err_d   = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.scan_code == SC_EXT)        state_d = EXT;
                        else if (bus.scan_code == SC_BRK)   state_d = BRK;
                        else if (bus.scan_code == SC_PAUSE) begin
                            state_d = SKIP;
                            skip_d  = SKW'(SKIP_BYTES);
                        end else if (!ignored)              do_make = 1'b1;
                    end
                    EXT: begin
                        if (bus.scan_code == SC_BRK)        state_d = EXT_BRK;
                        else if (bus.scan_code != SC_EXT) begin
                            do_make = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        do_brk  = 1'b1;
                        state_d = IDLE;
                    end
                    SKIP: begin
                        skip_d = skip_q - SKW'(1);
                        if (skip_q <= SKW'(1)) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
`ifdef KBD_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = IDLE;
            skip_d  = '0;
            err_d   = 1'b1;
        end
`endif
        // Press event only on a 0->1 edge so typematic repeats stay silent.
        if (do_make && hit) begin
            keys_d[key_idx] = 1'b1;
            evt_d[key_idx]  = ~keys_q[key_idx];
        end
        if (do_make && is_esc) begin
            if (!esc_q) pause_d = ~pause_q;
            esc_d = 1'b1;
        end
        if (do_brk && hit)    keys_d[key_idx] = 1'b0;
        if (do_brk && is_esc) esc_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            skip_q  <= '0;
            keys_q  <= '0;
            evt_q   <= '0;
            pause_q <= 1'b0;
            esc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            keys_q  <= keys_d;
            evt_q   <= evt_d;
            pause_q <= pause_d;
            esc_q   <= esc_d;
            err_q   <= err_d;
        end
    end

    assign bus.p1_actions = keys_q[4:0];
    assign bus.p2_actions = keys_q[9:5];
    assign bus.press_evt  = evt_q;
    assign bus.pause      = pause_q;
    assign bus.parse_err  = err_q;
endmodule

// File: tb/tb_keyboard_action_decoder.sv
// Scoreboard bench: each sent byte queues its expected outputs; a monitor checks after every strobe.
module tb_keyboard_action_decoder;
    typedef struct packed {
        logic [4:0] p1;
        logic [4:0] p2;
        logic [9:0] evt;
        logic       pz;
        logic       er;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic idle_err_ok = 1'b0;
    exp_t exp_q[$];

    keyboard_action_decoder_if bus();

    keyboard_action_decoder #(.TIMEOUT_CYCLES(16), .SKIP_BYTES(7)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t cur();
        exp_t a;
        a.p1 = bus.p1_actions; a.p2 = bus.p2_actions; a.evt = bus.press_evt;
        a.pz = bus.pause;      a.er = bus.parse_err;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [4:0] p1, input logic [4:0] p2,
                        input logic [9:0] evt, input logic pz, input logic er);
        exp_t e;
        e.p1 = p1; e.p2 = p2; e.evt = evt; e.pz = pz; e.er = er;
        exp_q.push_back(e);
        @(negedge clk);
        bus.scan_code  = b;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
    endtask

    // Monitor: outputs are registered, so the response sits after the strobe's edge.
    initial begin
        logic v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = bus.scan_valid;
            @(negedge clk);
            if (reset_n) begin
                if (v) begin
                    if (exp_q.size() == 0) check("unexpected_response", 32'(cur()), 32'hDEAD);
                    else begin
                        e = exp_q.pop_front();
                        check("byte_response", 32'(cur()), 32'(e));
                    end
                end else if (!idle_err_ok) begin
                    check("idle_pulses", {bus.press_evt, bus.parse_err}, 32'd0);
                end
            end
        end
    end

    initial begin
        bus.scan_code  = 8'h00;
        bus.scan_valid = 1'b0;
        #1 check("reset_outputs", 32'(cur()), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // make / break of W
        send(8'h1D, 5'b00001, 5'b0, 10'b0000000001, 0, 0);
        send(8'hF0, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h1D, 5'b00000, 5'b0, 10'b0, 0, 0);
        // typematic repeat
        send(8'h1D, 5'b00001, 5'b0, 10'b0000000001, 0, 0);
        send(8'h1D, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h1D, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'hF0, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h1D, 5'b00000, 5'b0, 10'b0, 0, 0);
        // extended arrow, plain 75 unmapped, extended break
        send(8'hE0, 5'b0, 5'b00000, 10'b0, 0, 0);
        send(8'h75, 5'b0, 5'b00001, 10'b0000100000, 0, 0);
        send(8'h75, 5'b0, 5'b00001, 10'b0, 0, 0);
        send(8'hE0, 5'b0, 5'b00001, 10'b0, 0, 0);
        send(8'hF0, 5'b0, 5'b00001, 10'b0, 0, 0);
        send(8'h75, 5'b0, 5'b00000, 10'b0, 0, 0);
        // pause-key sequence is swallowed
        send(8'h1D, 5'b00001, 5'b0, 10'b0000000001, 0, 0);
        send(8'hE1, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h14, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h77, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'hE1, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'hF0, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h14, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'hF0, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h77, 5'b00001, 5'b0, 10'b0, 0, 0);
        send(8'h1C, 5'b00101, 5'b0, 10'b0000000100, 0, 0);
        // overrun clears keys
        send(8'h29, 5'b10101, 5'b0, 10'b0000010000, 0, 0);
        send(8'hFF, 5'b00000, 5'b0, 10'b0, 0, 1);
        // Esc toggles pause on fresh make only
        send(8'h76, 5'b0, 5'b0, 10'b0, 1, 0);
        send(8'h76, 5'b0, 5'b0, 10'b0, 1, 0);
        send(8'hF0, 5'b0, 5'b0, 10'b0, 1, 0);
        send(8'h76, 5'b0, 5'b0, 10'b0, 1, 0);
        send(8'h76, 5'b0, 5'b0, 10'b0, 0, 0);
        // keypad Enter unmapped, plain Enter is p2 bomb, AA ignored, E0 E0 75
        send(8'hE0, 5'b0, 5'b00000, 10'b0, 0, 0);
        send(8'h5A, 5'b0, 5'b00000, 10'b0, 0, 0);
        send(8'h5A, 5'b0, 5'b10000, 10'b1000000000, 0, 0);
        send(8'hAA, 5'b0, 5'b10000, 10'b0, 0, 0);
        send(8'hE0, 5'b0, 5'b10000, 10'b0, 0, 0);
        send(8'hE0, 5'b0, 5'b10000, 10'b0, 0, 0);
        send(8'h75, 5'b0, 5'b10001, 10'b0000100000, 0, 0);
        // overrun inside an extended sequence
        send(8'hE0, 5'b0, 5'b10001, 10'b0, 0, 0);
        send(8'h00, 5'b0, 5'b00000, 10'b0, 0, 1);
        // async reset in the middle of an extended sequence
        send(8'h76, 5'b0, 5'b0, 10'b0, 1, 0);
        send(8'h1D, 5'b00001, 5'b0, 10'b0000000001, 1, 0);
        send(8'hE0, 5'b00001, 5'b0, 10'b0, 1, 0);
        #2 reset_n = 1'b0;
        #1 check("reset_mid_ext", 32'(cur()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h75, 5'b0, 5'b0, 10'b0, 0, 0);
        send(8'h1D, 5'b00001, 5'b0, 10'b0000000001, 0, 0);
`ifdef KBD_TIMEOUT_EN
        send(8'hE0, 5'b00001, 5'b0, 10'b0, 0, 0);
        idle_err_ok = 1'b1;
        repeat (15) @(negedge clk);
        check("timeout_early", 32'(bus.parse_err), 32'd0);
        @(negedge clk);
        check("timeout_err", 32'(bus.parse_err), 32'd1);
        @(negedge clk);
        idle_err_ok = 1'b0;
        send(8'h75, 5'b00001, 5'b0, 10'b0, 0, 0);
`endif
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
